// File: rtl/unique_stream_checker.sv
// unique_stream_checker: serial group-uniqueness checker; accepts N digits over valid/ready and
// reports duplicates, out-of-range digits and the first duplicated value.
module unique_stream_checker #(
    parameter int N           = 9,
    parameter int W           = 4,
    parameter bit ALLOW_BLANK = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_digit,
    output logic                     in_ready,
    output logic                     done,
    output logic                     unique_valid,
    output logic                     dup_found,
    output logic [W-1:0]             dup_digit,
    output logic                     range_err,
    output logic [$clog2(N+1)-1:0]   count,
    output logic [N-1:0]             seen_mask
);
    localparam int CW = $clog2(N+1);
    localparam logic [W-1:0] DMAX = W'(N);
    localparam logic [CW-1:0] CMAX = CW'(N);
    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_e;
    state_e state_q, state_d;
    logic [N-1:0] mask_q, mask_d, hot;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0] dup_digit_q, dup_digit_d;
    logic dup_q, dup_d, range_q, range_d, uv_q, uv_d;
    logic blank, illegal;
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        count_d     = count_q;
        dup_d       = dup_q;
        dup_digit_d = dup_digit_q;
        range_d     = range_q;
        uv_d        = uv_q;
        hot         = N'(1) << (in_digit - 1'b1);
        blank       = in_digit == '0;
        illegal     = blank || in_digit > DMAX;
        if (start) begin
            // start from any state restarts collection and discards a same-cycle digit
            state_d     = COLLECT;
            mask_d      = '0;
            count_d     = '0;
            dup_d       = 1'b0;
            dup_digit_d = '0;
            range_d     = 1'b0;
            uv_d        = 1'b0;
        end else if (state_q == REPORT) begin
            state_d = IDLE;
        end else if (state_q == COLLECT && in_valid) begin
            count_d = count_q + 1'b1;
            if (!(blank && ALLOW_BLANK)) begin
                if (illegal) begin
                    range_d = 1'b1;
                end else if (|(mask_q & hot)) begin
                    dup_d       = 1'b1;
                    dup_digit_d = dup_q ? dup_digit_q : in_digit;
                end else begin
                    mask_d = mask_q | hot;
                end
            end
            if (count_d == CMAX) begin
                state_d = REPORT;
                uv_d    = !dup_d && !range_d;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            count_q     <= '0;
            dup_q       <= 1'b0;
            dup_digit_q <= '0;
            range_q     <= 1'b0;
            uv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            dup_q       <= dup_d;
            dup_digit_q <= dup_digit_d;
            range_q     <= range_d;
            uv_q        <= uv_d;
        end
    end
    assign in_ready     = state_q == COLLECT;
    assign done         = state_q == REPORT;
    assign unique_valid = uv_q;
    assign dup_found    = dup_q;
    assign dup_digit    = dup_digit_q;
    assign range_err    = range_q;
    assign count        = count_q;
    assign seen_mask    = mask_q;
endmodule

// File: tb/tb_unique_stream_checker.sv
// tb_unique_stream_checker: directed bench for N=9 (blank off/on) and N=4 checker instances.
module tb_unique_stream_checker;
    logic clock = 1'b0;
    logic reset, start, in_valid;
    logic [3:0] in_digit;
    logic in_ready, done, unique_valid, dup_found, range_err;
    logic [3:0] dup_digit, count;
    logic [8:0] seen_mask;
    logic b_ready, b_done, b_uv, b_dup, b_range;
    logic [3:0] b_dd, b_count;
    logic [8:0] b_mask;
    logic s_start, s_valid;
    logic [2:0] s_digit;
    logic s_ready, s_done, s_uv, s_dup, s_range;
    logic [2:0] s_dd, s_count;
    logic [3:0] s_mask;
    int errors = 0, checks = 0, cyc = 0, nd = 0, nr = 0, c0 = 0;
    int seq [9];

    always #5 clock = ~clock;

    unique_stream_checker #(.N(9), .W(4), .ALLOW_BLANK(1'b0)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_digit(in_digit),
        .in_ready(in_ready), .done(done), .unique_valid(unique_valid), .dup_found(dup_found),
        .dup_digit(dup_digit), .range_err(range_err), .count(count), .seen_mask(seen_mask));

    unique_stream_checker #(.N(9), .W(4), .ALLOW_BLANK(1'b1)) dut_b (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_digit(in_digit),
        .in_ready(b_ready), .done(b_done), .unique_valid(b_uv), .dup_found(b_dup),
        .dup_digit(b_dd), .range_err(b_range), .count(b_count), .seen_mask(b_mask));

    unique_stream_checker #(.N(4), .W(3), .ALLOW_BLANK(1'b0)) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .in_valid(s_valid), .in_digit(s_digit),
        .in_ready(s_ready), .done(s_done), .unique_valid(s_uv), .dup_found(s_dup),
        .dup_digit(s_dd), .range_err(s_range), .count(s_count), .seen_mask(s_mask));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (done) nd++;
    endtask

    task automatic feed(input int from, input int to, input bit gaps);
        for (int i = from; i < to; i++) begin
            if (gaps) repeat (i % 3) begin
                in_valid = 1'b0;
                in_digit = 4'hF;
                tick();
            end
            in_valid = 1'b1;
            in_digit = 4'(seq[i]);
            if (in_ready) nr++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_s(input int a, input int b, input int c, input int d);
        int v [4];
        v = '{a, b, c, d};
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_digit = 3'(v[i]);
            tick();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_digit = '0;
        s_start = 1'b0; s_valid = 1'b0; s_digit = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_uv", int'(unique_valid), 0);
        chk("rst_mask", int'(seen_mask), 0);
        chk("rst_count", int'(count), 0);
        // back-to-back unique group
        go();
        chk("t1_ready", int'(in_ready), 1);
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c0 = cyc; nr = 0;
        feed(0, 9, 1'b0);
        chk("t1_nready", nr, 9);
        chk("t1_lat", cyc - c0, 9);
        chk("t1_done", int'(done), 1);
        chk("t1_uv", int'(unique_valid), 1);
        chk("t1_mask", int'(seen_mask), 'h1FF);
        chk("t1_count", int'(count), 9);
        chk("t1_dup", int'(dup_found), 0);
        tick();
        chk("t1_done_low", int'(done), 0);
        chk("t1_idle_ready", int'(in_ready), 0);
        chk("t1_uv_hold", int'(unique_valid), 1);
        in_valid = 1'b1; in_digit = 4'd2;
        tick();
        in_valid = 1'b0;
        chk("idle_count", int'(count), 9);
        // duplicates: first duplicate is 5
        go();
        seq = '{3, 5, 7, 5, 1, 3, 2, 4, 6};
        feed(0, 3, 1'b0);
        chk("t2_dup_early", int'(dup_found), 0);
        feed(3, 4, 1'b0);
        chk("t2_dup4", int'(dup_found), 1);
        chk("t2_dd4", int'(dup_digit), 5);
        feed(4, 9, 1'b0);
        chk("t2_done", int'(done), 1);
        chk("t2_dd", int'(dup_digit), 5);
        chk("t2_uv", int'(unique_valid), 0);
        chk("t2_mask", int'(seen_mask), 'h7F);
        tick();
        // out-of-range digit 12
        go();
        seq = '{1, 12, 2, 3, 4, 5, 6, 7, 8};
        feed(0, 1, 1'b0);
        chk("t3_range_early", int'(range_err), 0);
        feed(1, 2, 1'b0);
        chk("t3_range2", int'(range_err), 1);
        feed(2, 9, 1'b0);
        chk("t3_done", int'(done), 1);
        chk("t3_mask", int'(seen_mask), 'hFF);
        chk("t3_uv", int'(unique_valid), 0);
        chk("t3_dup", int'(dup_found), 0);
        chk("t3_b_range", int'(b_range), 1);
        chk("t3_b_uv", int'(b_uv), 0);
        tick();
        // digit 0: range error without blanks, blank with blanks
        go();
        seq = '{1, 0, 2, 3, 4, 5, 6, 7, 8};
        feed(0, 9, 1'b0);
        chk("t3z_range", int'(range_err), 1);
        chk("t3z_uv", int'(unique_valid), 0);
        chk("t3z_mask", int'(seen_mask), 'hFF);
        chk("t3z_b_range", int'(b_range), 0);
        chk("t3z_b_uv", int'(b_uv), 1);
        chk("t3z_b_done", int'(b_done), 1);
        tick();
        // alternating blanks, then again with in_valid gaps
        go();
        seq = '{1, 0, 3, 0, 5, 0, 7, 0, 9};
        feed(0, 9, 1'b0);
        chk("t4_b_done", int'(b_done), 1);
        chk("t4_b_uv", int'(b_uv), 1);
        chk("t4_b_mask", int'(b_mask), 'h155);
        chk("t4_b_count", int'(b_count), 9);
        chk("t4_uv", int'(unique_valid), 0);
        tick();
        go();
        c0 = cyc;
        feed(0, 9, 1'b1);
        chk("t4g_lat", cyc - c0, 18);
        chk("t4g_b_done", int'(b_done), 1);
        chk("t4g_b_uv", int'(b_uv), 1);
        chk("t4g_b_mask", int'(b_mask), 'h155);
        chk("t4g_b_count", int'(b_count), 9);
        tick();
        // abort via start after 4 digits, with a colliding digit
        nd = 0;
        go();
        seq = '{1, 2, 3, 3, 5, 6, 7, 8, 9};
        feed(0, 4, 1'b0);
        chk("t5_dup", int'(dup_found), 1);
        chk("t5_count4", int'(count), 4);
        start = 1'b1; in_valid = 1'b1; in_digit = 4'd9;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("t5_count0", int'(count), 0);
        chk("t5_dup_clr", int'(dup_found), 0);
        chk("t5_mask_clr", int'(seen_mask), 0);
        chk("t5_ready", int'(in_ready), 1);
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        feed(0, 9, 1'b0);
        chk("t5_uv", int'(unique_valid), 1);
        chk("t5_mask", int'(seen_mask), 'h1FF);
        tick();
        chk("t5_ndone", nd, 1);
        // start during the report cycle
        go();
        feed(0, 9, 1'b0);
        chk("t6_done", int'(done), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_ready", int'(in_ready), 1);
        chk("t6_count", int'(count), 0);
        chk("t6_uv", int'(unique_valid), 0);
        // reset mid-group
        feed(0, 4, 1'b0);
        chk("t7_count4", int'(count), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nd = 0;
        chk("t7_ready", int'(in_ready), 0);
        chk("t7_count", int'(count), 0);
        chk("t7_mask", int'(seen_mask), 0);
        tick(); tick();
        chk("t7_ndone", nd, 0);
        // N=4 instance
        feed_s(4, 3, 2, 1);
        chk("s_done", int'(s_done), 1);
        chk("s_uv", int'(s_uv), 1);
        chk("s_mask", int'(s_mask), 'hF);
        chk("s_count", int'(s_count), 4);
        tick();
        feed_s(1, 5, 2, 3);
        chk("s5_done", int'(s_done), 1);
        chk("s5_range", int'(s_range), 1);
        chk("s5_uv", int'(s_uv), 0);
        chk("s5_mask", int'(s_mask), 'h7);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
